// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
package program_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 1024;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHK,
    S_FINISH
  } load_state_t;

endpackage

// File: rtl/program_loader_checksum.sv
// 8-bit XOR accumulator over the loaded byte stream.
module loader_checksum
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] sum
);

  // Clear has priority so a new load starts from a zero checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit words (high byte first),
// writes them to instruction memory from address 0, then verifies an XOR
// checksum byte. The core is held in reset for the duration of the load.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [ADDR_W:0]    LEN,
  input  logic [BYTE_W-1:0]  BYTE_IN,
  input  logic               BYTE_VALID,
  output logic               BYTE_READY,
  output logic               IM_WE,
  output logic [ADDR_W-1:0]  IM_ADDR,
  output logic [INSTR_W-1:0] IM_DATA,
  output logic               CORE_RST,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  load_state_t state, state_nxt;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W-1:0] cnt_q;
  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] lo_q;
  logic [BYTE_W-1:0] csum;
  logic              err_q;
  logic              core_rst_q;

  logic xfer;
  logic len_ok;
  logic start_ok;
  logic start_bad;
  logic last_word;
  logic csum_ok;
  logic csum_en;

  assign xfer      = BYTE_VALID & BYTE_READY;
  assign len_ok    = (LEN != '0) && (LEN <= LEN_MAX);
  assign start_ok  = (state == S_IDLE) && START && len_ok;
  assign start_bad = (state == S_IDLE) && START && !len_ok;
  assign len_m1    = len_q - LEN_ONE;
  assign last_word = ({1'b0, cnt_q} == len_m1);
  assign csum_ok   = (BYTE_IN == csum);
  assign csum_en   = xfer && ((state == S_HI) || (state == S_LO));

  loader_checksum u_checksum (
    .clk  (CLK),
    .rst  (RST),
    .clr  (start_ok),
    .en   (csum_en),
    .data (BYTE_IN),
    .sum  (csum)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_ok) state_nxt = S_HI;
      S_HI:     if (xfer) state_nxt = S_LO;
      S_LO:     if (xfer) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = last_word ? S_CHK : S_HI;
      S_CHK:    if (xfer) state_nxt = csum_ok ? S_FINISH : S_IDLE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    BYTE_READY = 1'b0;
    IM_WE      = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    unique case (state)
      S_IDLE:   ;
      S_HI:     begin BYTE_READY = 1'b1; BUSY = 1'b1; end
      S_LO:     begin BYTE_READY = 1'b1; BUSY = 1'b1; end
      S_WRITE:  begin IM_WE = 1'b1; BUSY = 1'b1; end
      S_CHK:    begin BYTE_READY = 1'b1; BUSY = 1'b1; end
      S_FINISH: begin DONE = 1'b1; BUSY = 1'b1; end
      default:  ;
    endcase
  end

  // Datapath: length, word counter, byte latches, error pulse, sticky core reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      err_q <= start_bad || ((state == S_CHK) && xfer && !csum_ok);
      if (start_ok) begin
        len_q      <= LEN;
        cnt_q      <= '0;
        core_rst_q <= 1'b1;
      end
      if ((state == S_HI) && xfer) hi_q <= BYTE_IN;
      if ((state == S_LO) && xfer) lo_q <= BYTE_IN;
      if ((state == S_WRITE) && !last_word) cnt_q <= cnt_q + ADDR_W'(1);
      // Only a successful load releases the core; a checksum error leaves it held.
      if (state == S_FINISH) core_rst_q <= 1'b0;
    end
  end

  assign IM_ADDR  = cnt_q;
  assign IM_DATA  = {hi_q, lo_q};
  assign ERR      = err_q;
  assign CORE_RST = core_rst_q;

endmodule
